// File: rtl/host_rr_arbiter_if.sv
// Host/device bus bundle for host_rr_arbiter: per-host request lanes plus the
// single shared device port. The arbiter uses the slave view; hosts+device use master.
interface host_rr_arbiter_if #(
    parameter int NrHosts      = 2,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    // Host side
    logic [NrHosts-1:0]      host_req_i;
    logic [NrHosts-1:0]      host_we_i;
    logic [AddressWidth-1:0] host_addr_i  [NrHosts];
    logic [DataWidth/8-1:0]  host_be_i    [NrHosts];
    logic [DataWidth-1:0]    host_wdata_i [NrHosts];
    logic [NrHosts-1:0]      host_gnt_o;
    logic [NrHosts-1:0]      host_rvalid_o;
    logic [NrHosts-1:0]      host_err_o;
    logic [DataWidth-1:0]    host_rdata_o [NrHosts];

    // Device side
    logic                    dev_req_o;
    logic                    dev_we_o;
    logic [AddressWidth-1:0] dev_addr_o;
    logic [DataWidth/8-1:0]  dev_be_o;
    logic [DataWidth-1:0]    dev_wdata_o;
    logic                    dev_gnt_i;
    logic                    dev_rvalid_i;
    logic                    dev_err_i;
    logic [DataWidth-1:0]    dev_rdata_i;

    modport slave (
        input  host_req_i, host_we_i, host_addr_i, host_be_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
        output dev_req_o, dev_we_o, dev_addr_o, dev_be_o, dev_wdata_o,
        input  dev_gnt_i, dev_rvalid_i, dev_err_i, dev_rdata_i
    );

    modport master (
        output host_req_i, host_we_i, host_addr_i, host_be_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
        input  dev_req_o, dev_we_o, dev_addr_o, dev_be_o, dev_wdata_o,
        output dev_gnt_i, dev_rvalid_i, dev_err_i, dev_rdata_i
    );
endinterface

// File: rtl/host_rr_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid device port among NrHosts hosts;
// a small FIFO of granted host indices routes in-order responses back.
module host_rr_arbiter #(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    host_rr_arbiter_if.slave  bus,
    output logic              resp_unexpected_o
);
    localparam int IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = PtrW + 1;

    typedef logic [IdxW-1:0] idx_t;
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    arb_state_e state_q, state_d;
    idx_t       lock_idx_q, lock_idx_d;
    idx_t       last_grant_q;
    idx_t       sel_idx;
    logic       found;

    idx_t       fifo_mem [MaxOutstanding];
    ptr_t       wr_ptr_q, rd_ptr_q;
    cnt_t       count_q;
    logic       resp_unexpected_q;

    logic       any_req;
    logic       fifo_full;
    logic       fifo_empty;
    logic       dev_req;
    logic       accept;
    logic       pop;
    idx_t       head_idx;

    logic [AddressWidth-1:0] sel_addr;
    logic [DataWidth/8-1:0]  sel_be;
    logic [DataWidth-1:0]    sel_wdata;
    logic                    sel_we;

    function automatic idx_t rr_index(input idx_t base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NrHosts) sum = sum - NrHosts;
        return idx_t'(sum);
    endfunction

    assign any_req    = |bus.host_req_i;
    assign fifo_full  = (count_q == cnt_t'(MaxOutstanding));
    assign fifo_empty = (count_q == '0);

    // Full is judged on the registered count only, so a same-cycle pop never
    // reopens the device port and dev_rvalid_i has no path to dev_req_o.
    assign dev_req = !rst_i && any_req && !fifo_full;
    assign accept  = dev_req && bus.dev_gnt_i;
    assign pop     = bus.dev_rvalid_i && !fifo_empty;
    assign head_idx = fifo_mem[rd_ptr_q];

    // NOTE: always_comb uses blocking assignments with every output defaulted
    // first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        sel_idx = last_grant_q;
        found   = 1'b0;
        for (int k = 1; k <= NrHosts; k++) begin
            if (!found && bus.host_req_i[rr_index(last_grant_q, k)]) begin
                sel_idx = rr_index(last_grant_q, k);
                found   = 1'b1;
            end
        end
        if (state_q == ARB_LOCKED) sel_idx = lock_idx_q;
    end

    // A request shown to the device but not granted pins the selection until accepted.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            ARB_IDLE: begin
                if (dev_req && !bus.dev_gnt_i) begin
                    state_d    = ARB_LOCKED;
                    lock_idx_d = sel_idx;
                end
            end
            ARB_LOCKED: begin
                if (accept) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q      <= idx_t'(NrHosts - 1);
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            resp_unexpected_q <= 1'b0;
        end else begin
            if (accept) begin
                last_grant_q <= sel_idx;
                wr_ptr_q     <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (bus.dev_rvalid_i && fifo_empty) resp_unexpected_q <= 1'b1;
        end
    end

    // NOTE: the FIFO storage has no reset; validity is tracked by the reset
    // pointers and count, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (accept) fifo_mem[wr_ptr_q] <= sel_idx;
    end

    always_comb begin
        sel_addr  = bus.host_addr_i[sel_idx];
        sel_be    = bus.host_be_i[sel_idx];
        sel_wdata = bus.host_wdata_i[sel_idx];
        sel_we    = bus.host_we_i[sel_idx];
    end

    assign bus.dev_req_o   = dev_req;
    assign bus.dev_we_o    = dev_req && sel_we;
    assign bus.dev_addr_o  = dev_req ? sel_addr  : '0;
    assign bus.dev_be_o    = dev_req ? sel_be    : '0;
    assign bus.dev_wdata_o = dev_req ? sel_wdata : '0;

    always_comb begin
        for (int i = 0; i < NrHosts; i++) begin
            bus.host_gnt_o[i]    = accept && (sel_idx == idx_t'(i));
            bus.host_rvalid_o[i] = pop && (head_idx == idx_t'(i));
            bus.host_err_o[i]    = pop && (head_idx == idx_t'(i)) && bus.dev_err_i;
            bus.host_rdata_o[i]  = (pop && (head_idx == idx_t'(i))) ? bus.dev_rdata_i : '0;
        end
    end

    assign resp_unexpected_o = resp_unexpected_q;
endmodule
